// File: rtl/opd_pipe_pkg.sv
// Shared types for the decode stage: opcode map, ALU/compare op codes and the
// decoded bundle carried in the ID/EX register.
package opcodes_pkg;
  localparam int OPCODES_WIDTH = 6;

  typedef enum logic [OPCODES_WIDTH-1:0] {
    OP_ADD = 6'd0,
    OP_SUB = 6'd1,
    OP_AND = 6'd2,
    OP_OR  = 6'd3,
    OP_MUL = 6'd4,
    OP_DIV = 6'd5,
    OP_XOR = 6'd6,
    OP_LW  = 6'd7,
    OP_SW  = 6'd8,
    OP_BEQ = 6'd9,
    OP_BLT = 6'd10,
    OP_BLE = 6'd11
  } opcode_e;
endpackage

package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL, ALU_DIV, ALU_XOR
  } alu_op_e;
endpackage

package cmp_pkg;
  typedef enum logic [1:0] {
    CMP_NOP, CMP_BEQ, CMP_BLT, CMP_BLE
  } cmp_op_e;
endpackage

package decode_pkg;
  import opcodes_pkg::*;
  import alu_pkg::*;
  import cmp_pkg::*;

  // Bundle fields are sized for the widest supported configuration; narrower
  // instances zero-extend into them and slice on the way out.
  localparam int MAX_WORD_W = 64;
  localparam int MAX_SEL_W  = 8;

  typedef struct packed {
    logic [MAX_SEL_W-1:0]  select_a;
    logic [MAX_SEL_W-1:0]  select_b;
    logic [MAX_SEL_W-1:0]  select_c;
    logic [MAX_SEL_W-1:0]  dest;
    logic                  is_write_back;
    logic                  is_load;
    logic                  is_store;
    logic                  is_cmp;
    logic                  illegal;
    cmp_op_e               cmp_op;
    alu_op_e               alu_op;
    logic [MAX_WORD_W-1:0] offset;
  } decode_bundle_t;

  function automatic decode_bundle_t idle_bundle();
    decode_bundle_t b;
    b        = '0;
    b.alu_op = ALU_OR;
    b.cmp_op = CMP_NOP;
    return b;
  endfunction

  function automatic logic reads_a(input logic [OPCODES_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_XOR,
      OP_LW, OP_SW, OP_BEQ, OP_BLT, OP_BLE: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic reads_b(input logic [OPCODES_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_XOR,
      OP_SW, OP_BEQ, OP_BLT, OP_BLE: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/opd_decode.sv
// Combinational instruction decoder: splits the word into its fields and
// produces the control bundle for one instruction.
module opd_decode
  import opcodes_pkg::*, alu_pkg::*, cmp_pkg::*, decode_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REG   = 32
) (
  input  logic [REG_WIDTH-1:0] i_instruction,
  output decode_bundle_t       o_bundle
);
  localparam int REG_SELECT = $clog2(NUM_REG);
  localparam int IMM_W      = REG_WIDTH - OPCODES_WIDTH - 2 * REG_SELECT;

  opcode_e                 op;
  logic [REG_SELECT-1:0]   sel_a;
  logic [REG_SELECT-1:0]   sel_b;
  logic [REG_SELECT-1:0]   sel_c;
  logic [IMM_W-1:0]        imm;
  logic [REG_WIDTH-1:0]    imm_sext;
  logic [REG_WIDTH-1:0]    br_off;

  assign op       = opcode_e'(i_instruction[REG_WIDTH-1 -: OPCODES_WIDTH]);
  assign sel_a    = i_instruction[IMM_W + REG_SELECT +: REG_SELECT];
  assign sel_b    = i_instruction[IMM_W +: REG_SELECT];
  assign imm      = i_instruction[IMM_W-1:0];
  assign sel_c    = imm[IMM_W-1 -: REG_SELECT];
  assign imm_sext = {{(REG_WIDTH - IMM_W){imm[IMM_W-1]}}, imm};
  assign br_off   = imm_sext << 2;

  always_comb begin
    // NOTE: every field gets a value before the case so no path can infer a latch.
    o_bundle          = idle_bundle();
    o_bundle.select_a = MAX_SEL_W'(sel_a);
    o_bundle.select_b = MAX_SEL_W'(sel_b);
    o_bundle.select_c = MAX_SEL_W'(sel_c);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_XOR: begin
        o_bundle.is_write_back = 1'b1;
        o_bundle.dest          = MAX_SEL_W'(sel_c);
        case (op)
          OP_SUB:  o_bundle.alu_op = ALU_SUB;
          OP_AND:  o_bundle.alu_op = ALU_AND;
          OP_OR:   o_bundle.alu_op = ALU_OR;
          OP_MUL:  o_bundle.alu_op = ALU_MUL;
          OP_DIV:  o_bundle.alu_op = ALU_DIV;
          OP_XOR:  o_bundle.alu_op = ALU_XOR;
          default: o_bundle.alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        o_bundle.is_write_back = 1'b1;
        o_bundle.is_load       = 1'b1;
        o_bundle.alu_op        = ALU_ADD;
        o_bundle.offset        = MAX_WORD_W'(imm_sext);
        o_bundle.dest          = MAX_SEL_W'(sel_b);
      end
      OP_SW: begin
        o_bundle.is_store = 1'b1;
        o_bundle.alu_op   = ALU_ADD;
        o_bundle.offset   = MAX_WORD_W'(imm_sext);
      end
      OP_BEQ, OP_BLT, OP_BLE: begin
        o_bundle.is_cmp = 1'b1;
        o_bundle.alu_op = ALU_ADD;
        o_bundle.offset = MAX_WORD_W'(br_off);
        case (op)
          OP_BEQ:  o_bundle.cmp_op = CMP_BEQ;
          OP_BLT:  o_bundle.cmp_op = CMP_BLT;
          default: o_bundle.cmp_op = CMP_BLE;
        endcase
      end
      default: o_bundle.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/opd_pipe.sv
// Registered decode stage: ID/EX register with valid/ready handshakes,
// load-use bubble insertion, branch flush and a saturating bubble counter.
module opd_pipe
  import opcodes_pkg::*, alu_pkg::*, cmp_pkg::*, decode_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int NUM_REG    = 32,
  parameter int CNT_WIDTH  = 16,
  localparam int REG_SELECT = $clog2(NUM_REG)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_WIDTH-1:0]  i_instruction,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [REG_SELECT-1:0] o_select_a,
  output logic [REG_SELECT-1:0] o_select_b,
  output logic [REG_SELECT-1:0] o_select_c,
  output logic [REG_SELECT-1:0] o_dest,
  output logic                  o_is_write_back,
  output logic                  o_is_load,
  output logic                  o_is_store,
  output logic                  o_is_cmp,
  output logic                  o_illegal,
  output cmp_op_e               o_cmp_op,
  output alu_op_e               o_alu_op,
  output logic [REG_WIDTH-1:0]  o_offset,
  output logic [CNT_WIDTH-1:0]  o_bubble_count
);
  decode_bundle_t           dec_bundle;
  decode_bundle_t           bundle_q, bundle_d;
  logic                     valid_q, valid_d;
  logic [CNT_WIDTH-1:0]     bubble_cnt_q, bubble_cnt_d;
  logic [OPCODES_WIDTH-1:0] in_opcode;
  logic                     adv;
  logic                     hazard;

  opd_decode #(
    .REG_WIDTH (REG_WIDTH),
    .NUM_REG   (NUM_REG)
  ) u_decode (
    .i_instruction (i_instruction),
    .o_bundle      (dec_bundle)
  );

  assign in_opcode = i_instruction[REG_WIDTH-1 -: OPCODES_WIDTH];
  assign adv       = !valid_q || i_ready;

  // A load still sitting in ID/EX cannot forward to a consumer one slot behind.
  assign hazard = i_valid && valid_q && bundle_q.is_load &&
                  ((reads_a(in_opcode) && (dec_bundle.select_a == bundle_q.dest)) ||
                   (reads_b(in_opcode) && (dec_bundle.select_b == bundle_q.dest)));

  assign o_ready = (adv && !hazard) || i_flush;

  always_comb begin
    valid_d      = valid_q;
    bundle_d     = bundle_q;
    bubble_cnt_d = bubble_cnt_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (adv && hazard) begin
      valid_d = 1'b0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else if (adv && i_valid) begin
      bundle_d = dec_bundle;
      valid_d  = 1'b1;
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      valid_q      <= 1'b0;
      bundle_q     <= idle_bundle();
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      bundle_q     <= bundle_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_valid         = valid_q;
  assign o_select_a      = bundle_q.select_a[REG_SELECT-1:0];
  assign o_select_b      = bundle_q.select_b[REG_SELECT-1:0];
  assign o_select_c      = bundle_q.select_c[REG_SELECT-1:0];
  assign o_dest          = bundle_q.dest[REG_SELECT-1:0];
  assign o_is_write_back = bundle_q.is_write_back;
  assign o_is_load       = bundle_q.is_load;
  assign o_is_store      = bundle_q.is_store;
  assign o_is_cmp        = bundle_q.is_cmp;
  assign o_illegal       = bundle_q.illegal;
  assign o_cmp_op        = bundle_q.cmp_op;
  assign o_alu_op        = bundle_q.alu_op;
  assign o_offset        = bundle_q.offset[REG_WIDTH-1:0];
  assign o_bubble_count  = bubble_cnt_q;

  logic unused_bundle_hi;
  assign unused_bundle_hi = ^{bundle_q.select_a[MAX_SEL_W-1:REG_SELECT],
                              bundle_q.select_b[MAX_SEL_W-1:REG_SELECT],
                              bundle_q.select_c[MAX_SEL_W-1:REG_SELECT],
                              bundle_q.dest[MAX_SEL_W-1:REG_SELECT],
                              bundle_q.offset[MAX_WORD_W-1:REG_WIDTH]};
endmodule

// File: tb/tb_opd_pipe.sv
// Bench for opd_pipe: directed scenarios plus random traffic, checked each cycle
// against a transaction-level reference model (second instance has a 2-bit counter).
module tb_opd_pipe;
  import opcodes_pkg::*;
  import alu_pkg::*;
  import cmp_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] i_instruction = '0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic        i_flush = 1'b0;

  logic        o_ready, o_valid;
  logic [4:0]  o_select_a, o_select_b, o_select_c, o_dest;
  logic        o_is_write_back, o_is_load, o_is_store, o_is_cmp, o_illegal;
  cmp_op_e     o_cmp_op;
  alu_op_e     o_alu_op;
  logic [31:0] o_offset;
  logic [15:0] o_bubble_count;

  logic        d2_ready, d2_valid;
  logic [1:0]  d2_bubble_count;
  logic [4:0]  d2_unused_sa, d2_unused_sb, d2_unused_sc, d2_unused_dest;
  logic        d2_unused_wb, d2_unused_ld, d2_unused_st, d2_unused_cmp, d2_unused_ill;
  cmp_op_e     d2_unused_cop;
  alu_op_e     d2_unused_alu;
  logic [31:0] d2_unused_off;

  always #5 clk = ~clk;

  opd_pipe dut (
    .i_clk(clk), .i_rst(i_rst), .i_instruction(i_instruction), .i_valid(i_valid),
    .o_ready(o_ready), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_select_a(o_select_a), .o_select_b(o_select_b), .o_select_c(o_select_c),
    .o_dest(o_dest), .o_is_write_back(o_is_write_back), .o_is_load(o_is_load),
    .o_is_store(o_is_store), .o_is_cmp(o_is_cmp), .o_illegal(o_illegal),
    .o_cmp_op(o_cmp_op), .o_alu_op(o_alu_op), .o_offset(o_offset),
    .o_bubble_count(o_bubble_count)
  );

  opd_pipe #(.CNT_WIDTH(2)) dut_w2 (
    .i_clk(clk), .i_rst(i_rst), .i_instruction(i_instruction), .i_valid(i_valid),
    .o_ready(d2_ready), .i_flush(i_flush), .o_valid(d2_valid), .i_ready(i_ready),
    .o_select_a(d2_unused_sa), .o_select_b(d2_unused_sb), .o_select_c(d2_unused_sc),
    .o_dest(d2_unused_dest), .o_is_write_back(d2_unused_wb), .o_is_load(d2_unused_ld),
    .o_is_store(d2_unused_st), .o_is_cmp(d2_unused_cmp), .o_illegal(d2_unused_ill),
    .o_cmp_op(d2_unused_cop), .o_alu_op(d2_unused_alu), .o_offset(d2_unused_off),
    .o_bubble_count(d2_bubble_count)
  );

  typedef struct {
    logic [4:0]  a, b, c, dest;
    bit          wb, ld, st, cmp, ill, ra, rb;
    alu_op_e     alu;
    cmp_op_e     cop;
    logic [31:0] off;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   m_known  = 1'b0;
  bit   m_valid  = 1'b0;
  int   m_cnt    = 0;
  exp_t m_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                     input logic [4:0] b, input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  // Reference decode written from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t       e;
    logic [5:0] op;
    int         simm;
    op    = ins[31:26];
    e.a   = ins[25:21];
    e.b   = ins[20:16];
    e.c   = ins[15:11];
    simm  = int'(ins[15:0]);
    if (ins[15]) simm = simm - 65536;
    e.wb = 0; e.ld = 0; e.st = 0; e.cmp = 0; e.ill = 0; e.ra = 0; e.rb = 0;
    e.alu = ALU_OR; e.cop = CMP_NOP; e.off = '0; e.dest = '0;
    if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_XOR}) begin
      e.wb = 1; e.dest = e.c; e.ra = 1; e.rb = 1;
      case (op)
        OP_ADD:  e.alu = ALU_ADD;
        OP_SUB:  e.alu = ALU_SUB;
        OP_AND:  e.alu = ALU_AND;
        OP_OR:   e.alu = ALU_OR;
        OP_MUL:  e.alu = ALU_MUL;
        OP_DIV:  e.alu = ALU_DIV;
        default: e.alu = ALU_XOR;
      endcase
    end else if (op == OP_LW) begin
      e.wb = 1; e.ld = 1; e.alu = ALU_ADD; e.off = simm; e.dest = e.b; e.ra = 1;
    end else if (op == OP_SW) begin
      e.st = 1; e.alu = ALU_ADD; e.off = simm; e.ra = 1; e.rb = 1;
    end else if (op inside {OP_BEQ, OP_BLT, OP_BLE}) begin
      e.cmp = 1; e.alu = ALU_ADD; e.off = simm * 4; e.ra = 1; e.rb = 1;
      e.cop = (op == OP_BEQ) ? CMP_BEQ : (op == OP_BLT) ? CMP_BLT : CMP_BLE;
    end else begin
      e.ill = 1;
    end
    return e;
  endfunction

  task automatic check_outputs();
    check("valid", 64'(o_valid), 64'(m_valid));
    check("bubbles", 64'(o_bubble_count), 64'(sat(m_cnt, 65535)));
    check("valid_w2", 64'(d2_valid), 64'(m_valid));
    check("bubbles_w2", 64'(d2_bubble_count), 64'(sat(m_cnt, 3)));
    if (m_valid) begin
      check("select_a", 64'(o_select_a), 64'(m_b.a));
      check("select_b", 64'(o_select_b), 64'(m_b.b));
      check("select_c", 64'(o_select_c), 64'(m_b.c));
      if (m_b.wb) check("dest", 64'(o_dest), 64'(m_b.dest));
      check("is_write_back", 64'(o_is_write_back), 64'(m_b.wb));
      check("is_load", 64'(o_is_load), 64'(m_b.ld));
      check("is_store", 64'(o_is_store), 64'(m_b.st));
      check("is_cmp", 64'(o_is_cmp), 64'(m_b.cmp));
      check("illegal", 64'(o_illegal), 64'(m_b.ill));
      check("cmp_op", 64'(o_cmp_op), 64'(m_b.cop));
      check("alu_op", 64'(o_alu_op), 64'(m_b.alu));
      check("offset", 64'(o_offset), 64'(m_b.off));
    end
  endtask

  // One clock: check registered outputs, drive inputs, check o_ready, advance model.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] ins,
                       input logic rdy, input logic fl, output bit acc);
    exp_t in_e;
    bit   adv, haz, exp_rdy;
    if (m_known) check_outputs();
    i_rst = rst; i_valid = v; i_instruction = ins; i_ready = rdy; i_flush = fl;
    #1;
    in_e    = ref_decode(ins);
    adv     = !m_valid || rdy;
    haz     = v && m_valid && m_b.ld &&
              ((in_e.ra && in_e.a == m_b.dest) || (in_e.rb && in_e.b == m_b.dest));
    exp_rdy = fl || (adv && !haz);
    if (!rst && m_known) begin
      check("o_ready", 64'(o_ready), 64'(exp_rdy));
      check("o_ready_w2", 64'(d2_ready), 64'(exp_rdy));
    end
    acc = !rst && v && exp_rdy;
    if (rst) begin
      m_valid = 0; m_cnt = 0; m_known = 1;
    end else if (fl) begin
      m_valid = 0;
    end else if (adv && haz) begin
      m_valid = 0; m_cnt++;
    end else if (adv && v) begin
      m_b = in_e; m_valid = 1;
    end else if (adv) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    bit acc = 1'b0;
    for (int k = 0; k < 4 && !acc; k++) cycle(1'b0, 1'b1, ins, 1'b1, 1'b0, acc);
  endtask

  task automatic idle();
    bit acc;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          cnt_before;
    logic [31:0] rnd_ins;
    logic [5:0]  rnd_op;

    @(posedge clk);
    #1;
    // Reset wins over a simultaneous flush and valid instruction.
    cycle(1'b1, 1'b1, mk(OP_LW, 5'd1, 5'd2, 16'h1234), 1'b0, 1'b1, acc);
    cycle(1'b1, 1'b1, mk(OP_ADD, 5'd1, 5'd2, 16'h0), 1'b1, 1'b1, acc);
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_flags", 64'({o_is_write_back, o_is_load, o_is_store, o_is_cmp, o_illegal}), 64'(0));
    check("rst_selects", 64'({o_select_a, o_select_b, o_select_c, o_dest}), 64'(0));
    check("rst_offset", 64'(o_offset), 64'(0));
    check("rst_alu", 64'(o_alu_op), 64'(ALU_OR));
    check("rst_cmp", 64'(o_cmp_op), 64'(CMP_NOP));
    check("rst_count", 64'(o_bubble_count), 64'(0));

    // Back-to-back ALU ops r1,r2 -> r3.
    send(mk(OP_ADD, 5'd1, 5'd2, 16'(3 << 11)));
    check("add_dest", 64'(o_dest), 64'(3));
    check("add_alu", 64'(o_alu_op), 64'(ALU_ADD));
    send(mk(OP_XOR, 5'd1, 5'd2, 16'(3 << 11)));
    check("xor_alu", 64'(o_alu_op), 64'(ALU_XOR));
    check("xor_valid", 64'(o_valid), 64'(1));
    idle();

    // Load-use: LW a=2,b=5,imm=-4 then ADD reading r5.
    send(mk(OP_LW, 5'd2, 5'd5, 16'hFFFC));
    check("lw_offset", 64'(o_offset), 64'(32'hFFFF_FFFC));
    check("lw_dest", 64'(o_dest), 64'(5));
    cycle(1'b0, 1'b1, mk(OP_ADD, 5'd5, 5'd1, 16'(7 << 11)), 1'b1, 1'b0, acc);
    check("lu_bubble_valid", 64'(o_valid), 64'(0));
    send(mk(OP_ADD, 5'd5, 5'd1, 16'(7 << 11)));
    check("lu_add_dest", 64'(o_dest), 64'(7));
    check("lu_count", 64'(o_bubble_count), 64'(1));

    // Branch offset scaling.
    send(mk(OP_BLT, 5'd3, 5'd4, 16'd3));
    check("blt_offset", 64'(o_offset), 64'(12));
    check("blt_cmp_op", 64'(o_cmp_op), 64'(CMP_BLT));
    check("blt_is_cmp", 64'(o_is_cmp), 64'(1));
    check("blt_wb", 64'(o_is_write_back), 64'(0));

    // Backpressure: SUB held for 3 cycles, next instruction waits.
    send(mk(OP_SUB, 5'd4, 5'd5, 16'(6 << 11)));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, mk(OP_AND, 5'd7, 5'd8, 16'(9 << 11)), 1'b0, 1'b0, acc);
      check("bp_hold_alu", 64'(o_alu_op), 64'(ALU_SUB));
      check("bp_hold_dest", 64'(o_dest), 64'(6));
    end
    send(mk(OP_AND, 5'd7, 5'd8, 16'(9 << 11)));
    check("bp_next_alu", 64'(o_alu_op), 64'(ALU_AND));

    // Flush on the cycle a load-use hazard would fire.
    send(mk(OP_LW, 5'd0, 5'd7, 16'h0010));
    cnt_before = m_cnt;
    cycle(1'b0, 1'b1, mk(OP_ADD, 5'd7, 5'd7, 16'h0), 1'b1, 1'b1, acc);
    check("flush_valid", 64'(o_valid), 64'(0));
    check("flush_count", 64'(o_bubble_count), 64'(cnt_before));
    idle();

    // Flush while downstream is stalled clears the held bundle.
    send(mk(OP_SUB, 5'd1, 5'd1, 16'h0));
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
    check("stall_flush_valid", 64'(o_valid), 64'(0));

    // Unused opcode still travels down with o_valid high.
    send(mk(6'd63, 5'd2, 5'd3, 16'hABCD));
    check("illegal_flag", 64'(o_illegal), 64'(1));
    check("illegal_valid", 64'(o_valid), 64'(1));

    // Five more load-use pairs: 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      send(mk(OP_LW, 5'd1, 5'd9, 16'h0004));
      send(mk(OP_SW, 5'd2, 5'd9, 16'h0008));
    end
    check("sat_w2", 64'(d2_bubble_count), 64'(3));
    check("sat_w16", 64'(o_bubble_count), 64'(6));

    // Random traffic over a small register set to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      rnd_op  = ($urandom_range(0, 15) == 0) ? 6'd40 : 6'($urandom_range(0, 11));
      if ($urandom_range(0, 2) == 0) rnd_op = OP_LW;
      rnd_ins = mk(rnd_op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom()));
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), rnd_ins, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) == 0), acc);
    end

    // Reset in the middle of a stall drops the held instruction.
    send(mk(OP_MUL, 5'd1, 5'd2, 16'h0));
    cycle(1'b0, 1'b1, mk(OP_DIV, 5'd3, 5'd4, 16'h0), 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, mk(OP_DIV, 5'd3, 5'd4, 16'h0), 1'b0, 1'b0, acc);
    check("midstall_rst_valid", 64'(o_valid), 64'(0));
    check("midstall_rst_count", 64'(o_bubble_count), 64'(0));
    check("midstall_rst_alu", 64'(o_alu_op), 64'(ALU_OR));
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/opd_pipe.md
# opd_pipe

Parametrised, registered instruction-decode stage that replaces the purely combinational decoder between fetch and execute. Decodes an instruction word into register selects, control flags, ALU/compare ops and a sign-extended offset, then holds the result in an ID/EX pipeline register. Upstream and downstream connect through valid/ready handshakes. The stage detects load-use hazards and inserts one bubble for each, accepts a branch flush, flags illegal opcodes and counts inserted bubbles.

## Interface
- `REG_WIDTH`, 32: instruction and data word width.
- `NUM_REG`, 32: register-file depth; `REG_SELECT` = `$clog2(NUM_REG)`.
- `CNT_WIDTH`, 16: width of the bubble counter.
- `i_clk` in 1: the single clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_instruction` in `REG_WIDTH`: instruction word from fetch.
- `i_valid` in 1: `i_instruction` is valid.
- `o_ready` out 1: stage accepts `i_instruction` this cycle.
- `i_flush` in 1: branch taken; discard the held and incoming instruction.
- `o_valid` out 1: decoded bundle is valid.
- `i_ready` in 1: execute accepts the bundle.
- `o_select_a`, `o_select_b`, `o_select_c` out `REG_SELECT`: register fields.
- `o_dest` out `REG_SELECT`: write-back destination.
- `o_is_write_back`, `o_is_load`, `o_is_store`, `o_is_cmp`, `o_illegal` out 1 each: control flags.
- `o_cmp_op` out `cmp_op_e`, `o_alu_op` out `alu_op_e`: operation codes.
- `o_offset` out `REG_WIDTH`: sign-extended offset.
- `o_bubble_count` out `CNT_WIDTH`: count of inserted load-use bubbles, saturating.

## Operation
- **Field layout, MSB first:** opcode (`OPCODES_WIDTH` bits), then sel_a, then sel_b. The immediate is the low `IMM_W` = `REG_WIDTH − OPCODES_WIDTH − 2·REG_SELECT` bits. sel_c is the top `REG_SELECT` bits of the immediate.
- **Decode for ADD/SUB/AND/OR/MUL/DIV/XOR:**
  - write-back = 1; alu = that op; cmp = NOP; offset = 0.
  - dest = sel_c; sources are a and b.
- **Decode for LW:**
  - write-back = 1, load = 1, alu = ADD.
  - offset = sext(imm); dest = sel_b; source is a.
- **Decode for SW:** store = 1, alu = ADD, offset = sext(imm); sources are a and b.
- **Decode for BEQ/BLT/BLE:**
  - cmp = 1, cmp_op = that op, alu = ADD.
  - offset = sext(imm) << 2; sources are a and b.
- **Decode for any other opcode:**
  - illegal = 1; all other flags 0; alu = OR; cmp = NOP; offset = 0.
  - The bundle is still passed down with `o_valid` high.
- **Advance condition:** `adv` = `!o_valid || i_ready`.
- **Hazard condition:** `hazard` = `i_valid && o_valid && o_is_load && (o_dest` matches a source of the incoming instruction).
- `o_ready` = `adv && !hazard`, or 1 while `i_flush` is high.
- **Register update, highest priority first:**
  - `i_flush`: `o_valid` ← 0; the incoming instruction is consumed and dropped.
  - `adv && hazard`: `o_valid` ← 0 (one bubble) and `o_bubble_count` is incremented, saturating at all-ones.
  - `adv && i_valid`: bundle ← decode(`i_instruction`) and `o_valid` ← 1.
  - `adv && !i_valid`: `o_valid` ← 0.
  - Otherwise (`!adv`): hold the bundle.
- A bubble makes `o_valid` low, so the hazard clears the following cycle. The dependent instruction is then accepted.
- **Reset:**
  - `o_valid`, all flags and `o_bubble_count` = 0.
  - Selects, dest and offset = 0; `o_alu_op` = OR; `o_cmp_op` = NOP.
  - Reset has priority over flush and mid-stall state; any held instruction is lost.

## Timing
- Latency is 1 cycle from an accepted input (`i_valid && o_ready`) to `o_valid`.
- Throughput is 1 instruction per cycle without hazards; a load-use pair costs exactly one bubble cycle.
- `o_ready` is combinational from `i_valid`, `i_instruction`, `i_ready`, `i_flush` and the stage state. Every other output is registered.
- While `o_valid && !i_ready`, all outputs are stable and `o_ready` = 0.
- Flush and hazard in the same cycle: flush wins, and no bubble is counted.
- Flush while downstream is stalled: the held bundle is still cleared.
- `o_bubble_count` saturates and never wraps.

## Structure
- Into `opcodes_pkg`: opcode enum and `OPCODES_WIDTH`.
- Into `cmp_pkg` / `alu_pkg`: existing `cmp_op_e` / `alu_op_e`.
- New `decode_pkg` contents:
  - A `decode_bundle_t` struct with all decoded fields.
  - A function `reads_a`/`reads_b` per opcode.
- One combinational sub-module, `opd_decode`: instruction → `decode_bundle_t`, parametrised by `REG_WIDTH`/`NUM_REG`.
- `opd_pipe` owns the pipeline register, the hazard logic and the counter.

## Test plan
- **Reset then back-to-back ALU ops.**
  - Stimulus: ADD r1,r2→r3, then XOR, with `i_ready` = 1.
  - Response: `o_valid` rises the cycle after each input; `o_dest` = 3; `o_alu_op` = ADD then XOR; no bubbles.
- **Load-use.**
  - Stimulus: LW (a=2, b=5, imm=−4), then ADD reading r5.
  - Response: LW appears with `o_offset` = 0xFFFFFFFC and dest = 5; one cycle `o_valid` = 0 with `o_ready` = 0; ADD appears next; `o_bubble_count` = 1.
- **Branch offset.**
  - Stimulus: BLT with imm=3.
  - Response: `o_offset` = 12, `o_cmp_op` = BLT, `o_is_cmp` = 1, write-back = 0.
- **Backpressure.**
  - Stimulus: `i_ready` = 0 for 3 cycles with SUB held at the output.
  - Response: outputs stable and `o_ready` = 0; the next instruction is accepted the cycle `i_ready` returns.
- **Flush with a simultaneous load-use hazard.**
  - Stimulus: `i_flush` = 1 on the cycle the hazard would fire.
  - Response: `o_valid` = 0 next cycle, input dropped, `o_bubble_count` unchanged.
- **Illegal opcode and counter saturation.**
  - Stimulus: an unused opcode; separately, `CNT_WIDTH` = 2 with 5 load-use pairs.
  - Response: the illegal opcode gives `o_illegal` = 1 with `o_valid` = 1; the counter stays at 3.
